// File: rtl/debounce_pulse_gen_if.sv
// Button-side signal bundle for debounce_pulse_gen: raw button in, clean pulse and level out.
`timescale 1ns/1ps
interface debounce_pulse_gen_if;
  logic BTN;
  logic PULSE;
  logic LEVEL;

  modport master (output BTN, input PULSE, input LEVEL);
  modport slave  (input BTN, output PULSE, output LEVEL);
endinterface

// File: rtl/debounce_pulse_gen.sv
// Synchronises a bouncing push-button, confirms press/release by a stable-level count,
// and emits one registered PULSE per confirmed press plus a debounced LEVEL.
`timescale 1ns/1ps
module debounce_pulse_gen #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic                 C,
  input  logic                 CLR,
  debounce_pulse_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q;
  logic             s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  // Two-flop synchroniser; only s_q is ever seen by the FSM.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make s_q take the old s1_q, giving two real flop stages.
      s1_q <= bus.BTN;
      s_q  <= s1_q;
    end
  end

  // State register: FSM state, stability counter and registered outputs.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      // NOTE: every flop here is control state, so all of it is reset; nothing is left to power-up value.
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Next-state logic. cnt restarts on every WAIT entry and stops at CNT_LAST.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic, registered so PULSE and LEVEL change on the same edge as the state.
  always_comb begin
    pulse_d = (state_q == PRESS_WAIT) && (state_d == HELD);
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  assign bus.PULSE = pulse_q;
  assign bus.LEVEL = level_q;

endmodule
